vedic_mac_acc: RTL

Downstream accumulation stage for the 8-bit Vedic multiplier. It takes a stream of 16-bit unsigned products from the multiplier output over a valid/ready handshake and sums each block of products, where a block is terminated by `in_last`. It presents one registered result per block (sum, beat count, overflow flag) on an output handshake. It turns the purely combinational multiplier into a dot-product / MAC datapath.

---
 rtl/vedic_pkg.sv | 12 +
 rtl/vedic_mac_acc_if.sv | 29 ++
 rtl/vedic_mac_acc.sv | 72 +++++++
 3 files changed

// File: rtl/vedic_pkg.sv
// Shared constants and state encoding for the Vedic multiplier datapath.
package vedic_pkg;

    localparam int unsigned PROD_W = 16;
    localparam int unsigned OPND_W = 8;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/vedic_mac_acc_if.sv
// Product-in / block-result-out handshake bundle of the MAC accumulation stage.
interface vedic_mac_acc_if
    import vedic_pkg::*;
#(
    parameter int unsigned ACC_W = 24,
    parameter int unsigned LEN_W = 8
);

    logic                in_valid;
    logic                in_ready;
    logic [0:PROD_W-1]   in_prod;    // bit 0 is the MSB, matching the multiplier output
    logic                in_last;
    logic                out_valid;
    logic                out_ready;
    logic [ACC_W-1:0]    out_sum;
    logic [LEN_W-1:0]    out_count;
    logic                out_ovf;

    modport master (
        output in_valid, in_prod, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_prod, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );

endinterface

// File: rtl/vedic_mac_acc.sv
// Accumulates blocks of 16-bit products delimited by in_last and presents one
// registered sum/count/overflow result per block.
module vedic_mac_acc
    import vedic_pkg::*;
#(
    parameter int unsigned ACC_W = 24,
    parameter int unsigned LEN_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    vedic_mac_acc_if.slave  bus
);

    state_e             state_q;
    logic [ACC_W-1:0]   acc_q;
    logic [LEN_W-1:0]   cnt_q;
    logic               ovf_q;
    logic [ACC_W-1:0]   sum_q;
    logic [LEN_W-1:0]   count_q;
    logic               res_ovf_q;

    logic               beat_c;
    logic [ACC_W:0]     add_c;
    logic [LEN_W-1:0]   cnt_inc_c;
    logic               ovf_inc_c;

    // Next accumulator value with carry, saturating count and sticky overflow.
    always_comb begin
        beat_c    = bus.in_valid && (state_q == ACC);
        add_c     = {1'b0, acc_q} + (ACC_W+1)'(bus.in_prod);
        cnt_inc_c = (&cnt_q) ? cnt_q : cnt_q + LEN_W'(1);
        ovf_inc_c = ovf_q | add_c[ACC_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ACC;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            sum_q     <= '0;
            count_q   <= '0;
            res_ovf_q <= 1'b0;
        end else if (state_q == HOLD) begin
            if (bus.out_ready) begin
                state_q <= ACC;
            end
        end else if (beat_c) begin
            if (bus.in_last) begin
                sum_q     <= add_c[ACC_W-1:0];
                count_q   <= cnt_inc_c;
                res_ovf_q <= ovf_inc_c;
                acc_q     <= '0;
                cnt_q     <= '0;
                ovf_q     <= 1'b0;
                state_q   <= HOLD;
            end else begin
                acc_q <= add_c[ACC_W-1:0];
                cnt_q <= cnt_inc_c;
                ovf_q <= ovf_inc_c;
            end
        end
    end

    // Handshake flags come straight from the state register.
    assign bus.in_ready  = (state_q == ACC);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_sum   = sum_q;
    assign bus.out_count = count_q;
    assign bus.out_ovf   = res_ovf_q;

endmodule
